// File: rtl/dbus_master_pkg.sv
// dbus_master_pkg: shared size/state encodings, special addresses and alignment helper
package dbus_master_pkg;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_ILL = 2'b11} size_t;
  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;
  localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
  localparam logic [31:0] EXIT_ADDR = 32'hFF00_0000;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/dbus_master_if.sv
// dbus_master_if: external data bus; DDT resolves master and responder drivers
interface dbus_master_if;
  logic [31:0] DAD;
  logic MREQ;
  logic WRITE;
  logic [1:0] SIZE;
  logic ACKD_n;
  logic [31:0] ddt_o;
  logic ddt_oe;
  logic [31:0] ddt_s;
  logic ddt_se;
  wire [31:0] DDT;
  assign DDT = ddt_oe ? ddt_o : ddt_se ? ddt_s : 32'hz;
  modport master(output DAD, MREQ, WRITE, SIZE, ddt_o, ddt_oe, input ACKD_n, DDT);
  modport slave(input DAD, MREQ, WRITE, SIZE, DDT, output ACKD_n, ddt_s, ddt_se);
endinterface

// File: rtl/dbus_lane.sv
// dbus_lane: load extract/extend and store lane replication
module dbus_lane
  import dbus_master_pkg::*;
(
  input logic [1:0] size,
  input logic is_unsigned,
  input logic [31:0] raw,
  input logic [31:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] rep
);
  logic sx8, sx16;
  assign sx8 = !is_unsigned && raw[7];
  assign sx16 = !is_unsigned && raw[15];
  assign ext = size == SZ_BYTE ? {{24{sx8}}, raw[7:0]} :
               size == SZ_HALF ? {{16{sx16}}, raw[15:0]} : raw;
  assign rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
               size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
endmodule

// File: rtl/dbus_master.sv
// dbus_master: MEM-stage load/store unit driving an acknowledge-terminated data bus
module dbus_master
  import dbus_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  input logic req_valid,
  input logic req_write,
  input logic [1:0] req_size,
  input logic req_unsigned,
  input logic [31:0] req_addr,
  input logic [31:0] req_wdata,
  output logic stall,
  output logic [31:0] rdata,
  output logic rdata_valid,
  output logic err,
  dbus_master_if.master bus
);
  state_t state;
  logic [15:0] cnt;
  logic uns_q;
  logic [31:0] wdata_q;
  logic [31:0] ext, rep;
  dbus_lane lane (
    .size(bus.SIZE),
    .is_unsigned(uns_q),
    .raw(bus.DDT),
    .wdata(wdata_q),
    .ext(ext),
    .rep(rep)
  );
  assign bus.ddt_o = rep;
  assign bus.ddt_oe = state == BUS && bus.WRITE;
  // the pipeline is released in the completion cycle; reset also releases it
  assign stall = rst && req_valid && state != DONE && state != ERR;
  // bus-cycle FSM: latch request, hold bus until acknowledge or timeout, pulse result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      uns_q <= 1'b0;
      wdata_q <= '0;
      bus.DAD <= '0;
      bus.MREQ <= 1'b0;
      bus.WRITE <= 1'b0;
      bus.SIZE <= SZ_WORD;
      rdata <= '0;
      rdata_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (req_size == SZ_ILL || misaligned(req_size, req_addr[1:0])) begin
            state <= ERR;
            err <= 1'b1;
          end else begin
            state <= BUS;
            cnt <= '0;
            uns_q <= req_unsigned;
            wdata_q <= req_wdata;
            bus.DAD <= req_addr;
            bus.MREQ <= 1'b1;
            bus.WRITE <= req_write;
            bus.SIZE <= req_size;
          end
        end
        BUS: if (!bus.ACKD_n) begin
          state <= DONE;
          bus.MREQ <= 1'b0;
          rdata_valid <= 1'b1;
          if (!bus.WRITE) rdata <= ext;
        end else if (cnt + 16'd1 == 16'(TIMEOUT)) begin
          state <= ERR;
          bus.MREQ <= 1'b0;
          err <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DONE: state <= IDLE;
        ERR: state <= IDLE;
      endcase
    end
  end
endmodule
